// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - one-hot stage sequencer with bypass, watchdog, abort and continuous mode
module stage_sequencer #(
  parameter int NUM_STAGES  = 6,
  parameter int TIMEOUT_W   = 16,
  parameter int FRAME_CNT_W = 8,
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   abort,
  input  logic                   continuous,
  input  logic [NUM_STAGES-1:0]  stage_bypass,
  input  logic [TIMEOUT_W-1:0]   timeout_limit,
  output logic [NUM_STAGES-1:0]  stage_enable,
  input  logic [NUM_STAGES-1:0]  stage_done,
  output logic [IDX_W-1:0]       current_stage,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   error,
  output logic [IDX_W-1:0]       error_stage,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  logic [2:0]             r_state;
  logic [NUM_STAGES-1:0]  r_skip;
  logic [IDX_W-1:0]       r_idx;
  logic [TIMEOUT_W-1:0]   r_wdog;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic [IDX_W-1:0]       r_err_stage;
  logic                   r_frame_done;

  logic [IDX_W-1:0] w_first_idx;
  logic             w_all_bypass;
  logic [IDX_W-1:0] w_next_idx;
  logic             w_has_next;
  logic             w_start;
  logic             w_done_hit;
  logic             w_timeout;
  logic             w_enter_done;

  // First stage of a new frame comes from the live bypass input, not r_skip.
  always_comb begin
    w_first_idx  = '0;
    w_all_bypass = 1'b1;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (!stage_bypass[i]) begin
        w_first_idx  = IDX_W'(i);
        w_all_bypass = 1'b0;
      end
    end
  end

  always_comb begin
    w_next_idx = r_idx;
    w_has_next = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (!r_skip[i] && (i > int'(r_idx))) begin
        w_next_idx = IDX_W'(i);
        w_has_next = 1'b1;
      end
    end
  end

  assign w_start      = enable && ((r_state == S_IDLE) || ((r_state == S_DONE) && continuous));
  assign w_done_hit   = stage_done[r_idx];
  assign w_timeout    = (timeout_limit != '0) && (r_wdog == timeout_limit - TIMEOUT_W'(1));
  assign w_enter_done = !abort && ((w_start && w_all_bypass) ||
                                   ((r_state == S_RUN) && w_done_hit && !w_has_next));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_skip       <= '0;
      r_idx        <= '0;
      r_wdog       <= '0;
      r_frame_cnt  <= '0;
      r_err_stage  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_enter_done;
      if (w_enter_done) begin
        r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
      end
      if (abort) begin
        r_state <= S_IDLE;
      end else if (w_start) begin
        r_skip      <= stage_bypass;
        r_idx       <= w_first_idx;
        r_wdog      <= '0;
        r_err_stage <= '0;
        r_state     <= w_all_bypass ? S_DONE : S_RUN;
      end else begin
        case (r_state)
          S_RUN: begin
            if (r_wdog != '1) begin
              r_wdog <= r_wdog + TIMEOUT_W'(1);
            end
            // A done in the final watchdog cycle still completes the stage.
            if (w_done_hit) begin
              r_state <= w_has_next ? S_GAP : S_DONE;
            end else if (w_timeout) begin
              r_state     <= S_ERROR;
              r_err_stage <= r_idx;
            end
          end
          S_GAP: begin
            r_idx   <= w_next_idx;
            r_wdog  <= '0;
            r_state <= S_RUN;
          end
          S_DONE, S_ERROR: begin
            if (!enable) begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign stage_enable  = (r_state == S_RUN) ? (NUM_STAGES'(1) << r_idx) : '0;
  assign current_stage = r_idx;
  assign busy          = (r_state == S_RUN) || (r_state == S_GAP);
  assign frame_done    = r_frame_done;
  assign error         = (r_state == S_ERROR);
  assign error_stage   = r_err_stage;
  assign frame_count   = r_frame_cnt;

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - randomized bench for stage_sequencer against a frame-timeline model
module tb_stage_sequencer;

  localparam int NS = 6;
  localparam int TW = 16;
  localparam int MAXF = 320;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          abort;
  logic          continuous;
  logic [NS-1:0] stage_bypass;
  logic [TW-1:0] timeout_limit;
  logic [NS-1:0] stage_done;

  logic [NS-1:0] stage_enable, stage_enable_2;
  logic [2:0]    current_stage, current_stage_2;
  logic          busy, busy_2, frame_done, frame_done_2, error, error_2;
  logic [2:0]    error_stage, error_stage_2;
  logic [7:0]    frame_count;
  logic [1:0]    frame_count_2;

  stage_sequencer u_dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .abort(abort), .continuous(continuous),
    .stage_bypass(stage_bypass), .timeout_limit(timeout_limit), .stage_enable(stage_enable),
    .stage_done(stage_done), .current_stage(current_stage), .busy(busy), .frame_done(frame_done),
    .error(error), .error_stage(error_stage), .frame_count(frame_count)
  );

  stage_sequencer #(.FRAME_CNT_W(2)) u_dut_2 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .abort(abort), .continuous(continuous),
    .stage_bypass(stage_bypass), .timeout_limit(timeout_limit), .stage_enable(stage_enable_2),
    .stage_done(stage_done), .current_stage(current_stage_2), .busy(busy_2), .frame_done(frame_done_2),
    .error(error_2), .error_stage(error_stage_2), .frame_count(frame_count_2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NS-1:0] en;
    logic          busy, fdone, err;
    int            cur, es, f;
    logic [7:0]    fcnt;
    logic          d_en, d_cont;
    logic [NS-1:0] d_byp;
  } ent_t;

  ent_t          tl[$];
  int            lat_tab[MAXF][NS];
  logic [NS-1:0] byp_tab[MAXF];
  logic [7:0]    exp_fcnt = 8'd0;
  int            n_checks = 0;
  int            n_errors = 0;
  int            run_id = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [NS-1:0] en, input logic b, input logic fd, input logic er,
                      input int cur, input int es, input int f,
                      input logic d_en, input logic d_cont, input logic [NS-1:0] d_byp);
    ent_t e;
    e.en = en; e.busy = b; e.fdone = fd; e.err = er;
    e.cur = cur; e.es = es; e.f = f; e.fcnt = exp_fcnt;
    e.d_en = d_en; e.d_cont = d_cont; e.d_byp = d_byp;
    tl.push_back(e);
  endtask

  // Expected per-cycle waveform of a whole run, derived from the frame list.
  task automatic build_run(input int nf, input bit cont, input int limit);
    int q[$];
    logic [NS-1:0] oh;
    int s, lat, dur, last;
    bit to;
    tl.delete();
    push('0, 0, 0, 0, -1, -1, 0, 1'b1, cont, byp_tab[0]);
    for (int f = 0; f < nf; f++) begin
      q.delete();
      for (int i = 0; i < NS; i++) if (!byp_tab[f][i]) q.push_back(i);
      for (int j = 0; j < q.size(); j++) begin
        s = q[j];
        lat = lat_tab[f][s];
        to = (limit != 0) && ((lat == 0) || (lat > limit));
        dur = to ? limit : lat;
        oh = '0;
        oh[s] = 1'b1;
        repeat (dur) push(oh, 1, 0, 0, s, -1, f, 1'($urandom), cont, NS'($urandom));
        if (to) begin
          push('0, 0, 0, 1, s, s, f, 1'b1, 1'b0, NS'($urandom));
          push('0, 0, 0, 1, s, s, f, 1'b1, 1'b0, NS'($urandom));
          push('0, 0, 0, 1, s, s, f, 1'b0, 1'b0, NS'($urandom));
          push('0, 0, 0, 0, s, s, f, 1'b0, 1'b0, NS'($urandom));
          return;
        end
        if (j < q.size() - 1) push('0, 1, 0, 0, -1, -1, f, 1'($urandom), cont, NS'($urandom));
      end
      exp_fcnt++;
      last = (q.size() > 0) ? q[q.size()-1] : -1;
      if (cont && (f < nf - 1)) begin
        push('0, 0, 1, 0, last, -1, f, 1'b1, 1'b1, byp_tab[f+1]);
      end else begin
        push('0, 0, 1, 0, last, -1, f, 1'b1, 1'b0, NS'($urandom));
        push('0, 0, 0, 0, last, -1, f, 1'b0, 1'b0, NS'($urandom));
        push('0, 0, 0, 0, last, -1, f, 1'b0, 1'b0, NS'($urandom));
        return;
      end
    end
  endtask

  // Replays the timeline; each stage raises done on its lat-th enabled cycle.
  task automatic exec_run(input int limit);
    int cnt[NS];
    logic [NS-1:0] dn;
    string t;
    for (int i = 0; i < NS; i++) cnt[i] = 0;
    timeout_limit = TW'(limit);
    run_id++;
    for (int k = 0; k < tl.size(); k++) begin
      @(negedge clk);
      t = $sformatf("r%0d_k%0d", run_id, k);
      check({t, "_out"}, 32'({stage_enable, busy, frame_done, error, frame_count}),
            32'({tl[k].en, tl[k].busy, tl[k].fdone, tl[k].err, tl[k].fcnt}));
      check({t, "_out2"}, 32'({stage_enable_2, busy_2, frame_done_2, error_2, frame_count_2}),
            32'({tl[k].en, tl[k].busy, tl[k].fdone, tl[k].err, tl[k].fcnt[1:0]}));
      if (tl[k].cur >= 0) check({t, "_cur"}, 32'(current_stage), tl[k].cur);
      if (tl[k].es >= 0) check({t, "_es"}, 32'(error_stage), tl[k].es);
      for (int i = 0; i < NS; i++) begin
        if (stage_enable[i]) begin
          cnt[i]++;
          dn[i] = (lat_tab[tl[k].f][i] != 0) && (cnt[i] == lat_tab[tl[k].f][i]);
        end else begin
          cnt[i] = 0;
          dn[i] = 1'b0;
        end
      end
      stage_done   = dn | (NS'($urandom) & ~stage_enable);
      enable       = tl[k].d_en;
      continuous   = tl[k].d_cont;
      stage_bypass = tl[k].d_byp;
    end
  endtask

  task automatic set_lats(input int f, input int lo, input int hi);
    for (int i = 0; i < NS; i++) lat_tab[f][i] = $urandom_range(hi, lo);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    bit hit;
    int nf, lim;
    int lims[5] = '{0, 1, 2, 4, 6};
    reset_n = 1'b0; enable = 1'b0; abort = 1'b0; continuous = 1'b0;
    stage_bypass = '0; timeout_limit = '0; stage_done = '0;
    repeat (2) @(negedge clk);
    check("rst_out", 32'({stage_enable, busy, frame_done, error, frame_count}), 0);
    check("rst_idx", 32'({current_stage, error_stage}), 0);
    check("rst_out2", 32'({stage_enable_2, busy_2, frame_done_2, error_2, frame_count_2}), 0);
    reset_n = 1'b1;

    byp_tab[0] = '0;
    for (int i = 0; i < NS; i++) lat_tab[0][i] = 3;
    build_run(1, 0, 0); exec_run(0);

    byp_tab[0] = 6'b010110; set_lats(0, 1, 4);
    build_run(1, 0, 0); exec_run(0);

    byp_tab[0] = 6'b111111;
    build_run(1, 0, 0); exec_run(0);

    byp_tab[0] = '0; set_lats(0, 1, 4); lat_tab[0][2] = 0;
    build_run(1, 0, 10); exec_run(10);

    byp_tab[0] = '0; set_lats(0, 1, 5); lat_tab[0][1] = 5;
    build_run(1, 0, 5); exec_run(5);

    for (int f = 0; f < 5; f++) begin
      byp_tab[f] = '0;
      set_lats(f, 1, 1);
    end
    build_run(5, 1, 0); exec_run(0);

    for (int f = 0; f < 300; f++) byp_tab[f] = '1;
    build_run(300, 1, 0); exec_run(0);

    for (int r = 0; r < 25; r++) begin
      nf = $urandom_range(4, 1);
      lim = lims[$urandom_range(4, 0)];
      for (int f = 0; f < nf; f++) begin
        byp_tab[f] = ($urandom_range(4, 0) == 0) ? '1 : NS'($urandom);
        for (int i = 0; i < NS; i++)
          lat_tab[f][i] = ((lim != 0) && ($urandom_range(7, 0) == 0)) ? 0 : $urandom_range(6, 1);
      end
      build_run(nf, nf > 1, lim); exec_run(lim);
    end

    timeout_limit = '0; stage_bypass = '0; continuous = 1'b0; stage_done = '0;
    enable = 1'b1; hit = 1'b0;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge clk);
      if (stage_enable == NS'(8)) hit = 1'b1;
      else stage_done = stage_enable;
    end
    check("abort_reach", 32'(hit), 1);
    abort = 1'b1; stage_done = '0;
    @(negedge clk);
    check("abort_out", 32'({stage_enable, busy, frame_done, error, frame_count}), 32'(exp_fcnt));
    check("abort_cur", 32'(current_stage), 3);
    abort = 1'b0; enable = 1'b0;
    @(negedge clk);
    check("abort_idle", 32'({stage_enable, busy, frame_done, error, frame_count}), 32'(exp_fcnt));

    enable = 1'b1;
    repeat (2) @(negedge clk);
    check("prerst_busy", 32'({busy, stage_enable}), 32'({1'b1, NS'(1)}));
    reset_n = 1'b0;
    @(negedge clk);
    exp_fcnt = 8'd0;
    check("midrst_out", 32'({stage_enable, busy, frame_done, error, frame_count}), 0);
    check("midrst_idx", 32'({current_stage, error_stage}), 0);
    check("midrst_out2", 32'({stage_enable_2, busy_2, frame_done_2, error_2, frame_count_2}), 0);
    reset_n = 1'b1; enable = 1'b0;
    @(negedge clk);
    check("postrst_idle", 32'({stage_enable, busy, error, frame_count}), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Parametrised successor to the fixed six-stage edge-detection pipeline controller.
- Sequences NUM_STAGES processing stages one at a time using one-hot enable/done handshakes.
- Adds a per-frame stage bypass mask, a per-stage watchdog timeout with error capture, abort, continuous (back-to-back frame) mode and a frame counter.
- Sits between the top-level host/config registers and the stage datapaths (gaussian, sobel, suppression, threshold, hysteresis, ...).

Parameters:
NUM_STAGES, 6, number of sequenced stages; stage 0 runs first.
TIMEOUT_W, 16, width of the watchdog limit and counter.
FRAME_CNT_W, 8, width of the completed-frame counter.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset_n  input  1  synchronous active-low reset.
enable  input  1  level; start and keep the sequence armed.
abort  input  1  level; force return to IDLE.
continuous  input  1  1 = restart a new frame automatically after DONE.
stage_bypass  input  NUM_STAGES  1 = skip stage i; sampled at frame start only.
timeout_limit  input  TIMEOUT_W  max cycles per stage; 0 = watchdog disabled.
stage_enable  output  NUM_STAGES  one-hot enable to the active stage.
stage_done  input  NUM_STAGES  done from stage i; only the active stage's bit is observed.
current_stage  output  $clog2(NUM_STAGES)  index of the active/last stage.
busy  output  1  high in RUN or GAP.
frame_done  output  1  one-cycle pulse on entry to DONE.
error  output  1  high while in ERROR.
error_stage  output  $clog2(NUM_STAGES)  stage that timed out; held until the next frame start.
frame_count  output  FRAME_CNT_W  completed frames, wraps modulo 2^FRAME_CNT_W.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE; skip_q=0; idx=0; wdog=0; frame_count=0; error_stage=0.
  - All outputs 0.
- Outputs are Moore-decoded from registered state and idx. There is no combinational input-to-output path.
  - stage_enable = onehot(idx) only in RUN; 0 otherwise.
- States: IDLE, RUN, GAP, DONE, ERROR.
- Frame start (from IDLE with enable=1 and abort=0, or from DONE with continuous=1 and enable=1):
  - Latch skip_q = stage_bypass.
  - Set idx = lowest i with skip_q[i]=0, clear wdog, then go to RUN.
  - If all stages are bypassed, go directly to DONE.
  - stage_enable rises the cycle after the start condition is sampled.
- RUN:
  - wdog increments each cycle and saturates.
  - If stage_done[idx]=1:
    - If a higher non-skipped stage exists, go to GAP.
    - Otherwise go to DONE.
  - Otherwise, if timeout_limit!=0 and wdog==timeout_limit-1: go to ERROR and set error_stage=idx.
  - stage_done has priority over timeout in the same cycle.
  - stage_done bits other than idx are ignored.
- GAP:
  - One cycle with all enables low, which lets each stage clear its own done.
  - idx advances to the next non-skipped stage, wdog clears, then go to RUN.
  - Done-to-next-enable latency is 2 cycles.
- DONE:
  - frame_done pulses for 1 cycle on entry and frame_count increments on entry.
  - Stays in DONE while enable=1 and continuous=0.
  - enable=0 → IDLE.
  - continuous=1 and enable=1 → immediate new frame start.
- ERROR:
  - error=1, stage_enable=0.
  - Stays until enable=0, then goes to IDLE.
  - frame_count is not incremented.
- abort=1 in any state → IDLE next cycle with all enables low.
  - frame_count and error_stage are retained.
  - abort has priority over every other transition.
- enable dropping during RUN or GAP does not stop the frame; only abort does.
- current_stage = idx in all states. It holds its last value in IDLE, DONE and ERROR.
- A stage_bypass change mid-frame has no effect until the next frame start.

Test Plan:
- Default parameters, bypass=0, limit=0, enable=1, each stage asserts done 3 cycles after its enable → enables walk 0..5 one-hot with 1-cycle gaps; frame_done pulses once; frame_count=1; busy low after DONE.
- bypass=6'b010110 → only stages 0, 3 and 5 are enabled, in that order; stages 1, 2 and 4 never see enable; bypass=6'b111111 → frame_done one cycle after enable with no stage enabled.
- limit=10, stage 2 never asserts done → stage_enable[2] is high for exactly 10 cycles, then error=1 and error_stage=2; enable=0 → IDLE with error=0.
- limit=5, stage 1 asserts done on exactly its 5th enabled cycle → no error and the sequence advances to stage 2 (done beats timeout).
- continuous=1, FRAME_CNT_W=2, done after 1 cycle → 5 back-to-back frames; frame_count goes 1, 2, 3, 0, 1; a new frame starts the cycle after each frame_done.
- abort=1 mid-stage 3 → all enables 0 next cycle, state IDLE, frame_count unchanged; reset_n=0 mid-RUN → all outputs 0 after the next edge.
